// File: rtl/l2_block_fetch.sv
// l2_block_fetch: next-level memory model that serves L1 misses.
// A miss is held for a fixed access latency, then the block arrives one beat per
// cycle (optionally critical-word-first) and is offered to the find/update stage.
// Backing data is a pure function of the word address, so every bit is predictable.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no fetch in flight; accepts miss_req_i
// S_WAIT  | request issued, access latency timer running
// S_BURST | one beat per cycle written into its natural block slot
// S_DONE  | block complete and stable; waits for trace_ready_i
module l2_block_fetch #(
  parameter int block_size_byte = 16,
  parameter int beat_bytes      = 4,
  parameter int mem_latency     = 8,
  parameter int cwf             = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         trace_ready_i,
  input  logic                         miss_req_i,
  input  logic [31:0]                  miss_addr_i,
  output logic [block_size_byte*8-1:0] block_o,
  output logic                         block_ready_o,
  output logic                         busy_o,
  output logic [4:0]                   miss_latency_o,
  output logic [15:0]                  fetch_count_o
);

  localparam int BEATS    = block_size_byte / beat_bytes;
  localparam int BEAT_W   = beat_bytes * 8;
  localparam int BLK_W    = block_size_byte * 8;
  localparam int WPB      = beat_bytes / 4;
  localparam int OFF_W    = $clog2(block_size_byte);
  localparam int IDX_W    = $clog2(BEATS);
  localparam int WCNT_W   = $clog2(mem_latency + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         base_q, base_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic [4:0]          lat_q, lat_d;
  logic [BLK_W-1:0]    block_q, block_d;
  logic [4:0]          mlat_q, mlat_d;
  logic [15:0]         fcnt_q, fcnt_d;

  logic [OFF_W-1:0]    off_w;
  logic [31:0]         base_w;
  logic [IDX_W-1:0]    fb_w;
  logic [IDX_W-1:0]    idx_next_w;
  logic [4:0]          lat_inc_w;
  logic [BEAT_W-1:0]   beat_data;

  assign off_w      = miss_addr_i[OFF_W-1:0];
  assign base_w     = {miss_addr_i[31:OFF_W], {OFF_W{1'b0}}};
  assign fb_w       = (cwf != 0) ? IDX_W'(off_w / OFF_W'(beat_bytes)) : '0;
  assign idx_next_w = (idx_q == IDX_W'(BEATS - 1)) ? '0 : idx_q + IDX_W'(1);
  assign lat_inc_w  = (lat_q == 5'd31) ? 5'd31 : lat_q + 5'd1;

  // Beat payload: each 32-bit word is its own byte address XOR a fixed pattern.
  always_comb begin
    beat_data = '0;
    for (int w = 0; w < WPB; w++) begin
      beat_data[w*32 +: 32] = (base_q + 32'(idx_q) * 32'(beat_bytes) + 32'(4 * w))
                              ^ 32'hA5A5_A5A5;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      beat_cnt_q <= '0;
      wait_q     <= '0;
      lat_q      <= '0;
      block_q    <= '0;
      mlat_q     <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      beat_cnt_q <= beat_cnt_d;
      wait_q     <= wait_d;
      lat_q      <= lat_d;
      block_q    <= block_d;
      mlat_q     <= mlat_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Next-state and datapath updates; trace_ready_i aborts everything but keeps results.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    beat_cnt_d = beat_cnt_q;
    wait_d     = wait_q;
    lat_d      = lat_q;
    block_d    = block_q;
    mlat_d     = mlat_q;
    fcnt_d     = fcnt_q;
    if (trace_ready_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_req_i) begin
            base_d     = base_w;
            idx_d      = fb_w;
            beat_cnt_d = IDX_W'(BEATS - 1);
            // The first WAIT cycle issues the request; the timer then covers mem_latency.
            wait_d     = WCNT_W'(mem_latency);
            lat_d      = '0;
            block_d    = '0;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          lat_d = lat_inc_w;
          if (wait_q == '0) begin
            state_d = S_BURST;
          end else begin
            wait_d = wait_q - WCNT_W'(1);
          end
        end
        S_BURST: begin
          lat_d = lat_inc_w;
          block_d[int'(idx_q)*BEAT_W +: BEAT_W] = beat_data;
          idx_d = idx_next_w;
          if (beat_cnt_q == '0) begin
            state_d = S_DONE;
            mlat_d  = lat_inc_w;
            fcnt_d  = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;
          end else begin
            beat_cnt_d = beat_cnt_q - IDX_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign block_o        = block_q;
  assign block_ready_o  = (state_q == S_DONE);
  assign busy_o         = (state_q == S_WAIT) || (state_q == S_BURST);
  assign miss_latency_o = mlat_q;
  assign fetch_count_o  = fcnt_q;

endmodule

// File: tb/tb_l2_block_fetch.sv
// Bench for l2_block_fetch: three instances share stimulus (defaults, cwf=0, mem_latency=30).
module tb_l2_block_fetch;

  logic        clk = 1'b0;
  logic        rst, trace_ready, miss_req;
  logic [31:0] miss_addr;

  logic [127:0] blk_a, blk_b, blk_c;
  logic         rdy_a, rdy_b, rdy_c;
  logic         busy_a, busy_b, busy_c;
  logic [4:0]   lat_a, lat_b, lat_c;
  logic [15:0]  cnt_a, cnt_b, cnt_c;

  int n_cmp = 0;
  int n_err = 0;

  localparam int NOMINAL = 8 + 4 + 1;

  always #5 clk = ~clk;

  l2_block_fetch dut_a (
    .clk_i(clk), .rst_i(rst), .trace_ready_i(trace_ready), .miss_req_i(miss_req),
    .miss_addr_i(miss_addr), .block_o(blk_a), .block_ready_o(rdy_a), .busy_o(busy_a),
    .miss_latency_o(lat_a), .fetch_count_o(cnt_a));

  l2_block_fetch #(.cwf(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .trace_ready_i(trace_ready), .miss_req_i(miss_req),
    .miss_addr_i(miss_addr), .block_o(blk_b), .block_ready_o(rdy_b), .busy_o(busy_b),
    .miss_latency_o(lat_b), .fetch_count_o(cnt_b));

  l2_block_fetch #(.mem_latency(30)) dut_c (
    .clk_i(clk), .rst_i(rst), .trace_ready_i(trace_ready), .miss_req_i(miss_req),
    .miss_addr_i(miss_addr), .block_o(blk_c), .block_ready_o(rdy_c), .busy_o(busy_c),
    .miss_latency_o(lat_c), .fetch_count_o(cnt_c));

  typedef struct {
    logic        r;
    logic        t;
    logic        m;
    logic [31:0] a;
    logic        er;
    logic        eb;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[10];

  // Reference model state: a fetch is just "cycles since accept" plus completion flag.
  logic         m_act, m_done;
  int           m_t;
  logic [31:0]  m_addr;
  logic [127:0] m_blk;
  logic [4:0]   m_lat;
  logic [15:0]  m_cnt;

  function automatic logic [127:0] exp_block(input logic [31:0] a);
    logic [127:0] b;
    logic [31:0]  base;
    base = {a[31:4], 4'h0};
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = (base + 32'(4 * w)) ^ 32'hA5A5_A5A5;
    return b;
  endfunction

  function automatic logic [127:0] slot_mask(input logic [3:0] slots);
    logic [127:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (slots[k]) m[k*32 +: 32] = 32'hFFFF_FFFF;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic m, input logic [31:0] a);
    rst = r; trace_ready = t; miss_req = m; miss_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_act = 0; m_done = 0; m_blk = '0; m_lat = '0; m_cnt = '0;
    end else if (trace_ready) begin
      m_act = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 1;
    end else if (m_act) begin
      m_t++;
      if (m_t == NOMINAL) begin
        m_act = 0; m_done = 1; m_lat = 5'(NOMINAL);
        m_blk = exp_block(m_addr);
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
    end else if (miss_req) begin
      m_act = 1; m_t = 0; m_addr = miss_addr;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_a, t_b, t_c;
    logic [15:0] cnt_before;
    logic [127:0] e;

    rst = 1; trace_ready = 0; miss_req = 0; miss_addr = '0;

    // Control-path vectors: reset, accept, ignore, abort, priority, reset-in-WAIT.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h1238, 1'b0, 1'b1, 16'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h5000, 1'b0, 1'b1, 16'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 16'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h1238, 1'b0, 1'b0, 16'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h1238, 1'b0, 1'b1, 16'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 16'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 16'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h1238, 1'b0, 1'b1, 16'd0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 16'd0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].t, tbl[i].m, tbl[i].a);
      chk($sformatf("tbl%0d block_ready", i), 128'(rdy_a), 128'(tbl[i].er));
      chk($sformatf("tbl%0d busy", i), 128'(busy_a), 128'(tbl[i].eb));
      chk($sformatf("tbl%0d fetch_count", i), 128'(cnt_a), 128'(tbl[i].ec));
      if (tbl[i].r) begin
        chk($sformatf("tbl%0d reset block", i), blk_a, '0);
        chk($sformatf("tbl%0d reset miss_latency", i), 128'(lat_a), '0);
      end
    end

    // Main miss on all three instances, miss_req held high throughout.
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h0000_1238);
    t_a = -1; t_b = -1; t_c = -1;
    e = exp_block(32'h1238);
    for (int k = 1; k <= 45; k++) begin
      step(0, 0, 1, 32'h0000_1238);
      if (rdy_a && t_a < 0) t_a = k;
      if (rdy_b && t_b < 0) t_b = k;
      if (rdy_c && t_c < 0) t_c = k;
      if (k == 10) begin
        chk("cwf1 first beat slot2", blk_a, e & slot_mask(4'b0100));
        chk("cwf0 first beat slot0", blk_b, e & slot_mask(4'b0001));
      end
      if (k == 11) begin
        chk("cwf1 second beat slot3", blk_a, e & slot_mask(4'b1100));
        chk("cwf0 second beat slot1", blk_b, e & slot_mask(4'b0011));
      end
      if (k == 12) chk("cwf1 third beat wraps slot0", blk_a, e & slot_mask(4'b1101));
    end
    chk("cwf1 ready cycle", 128'(t_a), 128'(NOMINAL));
    chk("cwf0 ready cycle", 128'(t_b), 128'(NOMINAL));
    chk("lat30 ready cycle", 128'(t_c), 128'(35));
    chk("cwf1 block", blk_a, e);
    chk("cwf0 block", blk_b, e);
    chk("lat30 block", blk_c, e);
    chk("cwf1 miss_latency", 128'(lat_a), 128'(13));
    chk("cwf0 miss_latency", 128'(lat_b), 128'(13));
    chk("lat30 miss_latency saturates", 128'(lat_c), 128'(31));
    chk("held miss_req single fetch", 128'(cnt_a), 128'(1));
    chk("lat30 single fetch", 128'(cnt_c), 128'(1));
    chk("done not busy", 128'(busy_a), 128'(0));
    chk("done ready held", 128'(rdy_a), 128'(1));

    // cwf=0 with an unaligned critical word still starts at beat 0.
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'h0000_123C);
    for (int k = 1; k <= 13; k++) begin
      step(0, 0, 0, 0);
      if (k == 10) chk("cwf0 123C first beat slot0", blk_b, e & slot_mask(4'b0001));
      if (k == 12) chk("cwf0 123C not ready at 12", 128'(rdy_b), 128'(0));
    end
    chk("cwf0 123C ready", 128'(rdy_b), 128'(1));
    chk("cwf0 123C block", blk_b, exp_block(32'h123C));
    chk("cwf0 123C miss_latency", 128'(lat_b), 128'(13));

    // Abort during BURST beat 1, then a normal fetch.
    step(0, 1, 0, 0);
    cnt_before = cnt_a;
    step(0, 0, 1, 32'h0000_2004);
    for (int k = 1; k <= 10; k++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("abort busy", 128'(busy_a), 128'(0));
    chk("abort ready", 128'(rdy_a), 128'(0));
    chk("abort fetch_count", 128'(cnt_a), 128'(cnt_before));
    chk("abort miss_latency kept", 128'(lat_a), 128'(13));
    step(0, 0, 0, 0);
    chk("abort stays idle", 128'(busy_a | rdy_a), 128'(0));
    step(0, 0, 1, 32'h0000_4444);
    for (int k = 1; k <= 13; k++) begin
      step(0, 0, 0, 0);
      if (k == 12) chk("refetch not ready at 12", 128'(rdy_a), 128'(0));
    end
    chk("refetch ready", 128'(rdy_a), 128'(1));
    chk("refetch fetch_count", 128'(cnt_a), 128'(cnt_before + 16'd1));
    chk("refetch block", blk_a, exp_block(32'h4444));

    // Randomized traffic against the timeline model.
    step(1, 0, 0, 0);
    m_act = 0; m_done = 0; m_t = 0; m_addr = '0; m_blk = '0; m_lat = '0; m_cnt = '0;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      trace_ready = ($urandom_range(0, 24) == 0);
      miss_req    = ($urandom_range(0, 3) != 0);
      miss_addr   = $urandom;
      model_edge();
      @(posedge clk);
      #1;
      chk("rand block_ready", 128'(rdy_a), 128'(m_done));
      chk("rand busy", 128'(busy_a), 128'(m_act));
      chk("rand fetch_count", 128'(cnt_a), 128'(m_cnt));
      chk("rand miss_latency", 128'(lat_a), 128'(m_lat));
      if (m_done) chk("rand block", blk_a, m_blk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
